// File: rtl/dmi_dr_ctrl.sv
// -----------------------------------------------------------------------------
// dmi_dr_ctrl
//
// DTM data-register controller for the debug transport. It owns the DTMCS and
// DMI shift registers and turns completed DMI scans into valid/ready request/
// response transactions toward the debug module. Everything runs on TCK.
//
// Ports:
//   clk_i             TCK from the TAP
//   rst_i             synchronous, active-high reset
//   dmi_clear_i       TAP test-logic reset, synchronous soft clear
//   capture_i         Capture-DR strobe
//   shift_i           Shift-DR strobe
//   update_i          Update-DR strobe
//   tdi_i             serial data in
//   dtmcs_select_i    DTMCS chain selected (wins over dmi_select_i)
//   dmi_select_i      DMI chain selected
//   dtmcs_tdo_o       serial out, DTMCS chain
//   dmi_tdo_o         serial out, DMI chain
//   dmi_req_valid_o   request valid
//   dmi_req_ready_i   request accepted
//   dmi_req_addr_o    request address
//   dmi_req_op_o      request op (1 = read, 2 = write)
//   dmi_req_data_o    write data
//   dmi_resp_valid_i  response valid
//   dmi_resp_ready_o  response accept
//   dmi_resp_data_i   read data
//   dmi_resp_resp_i   response status (0 = ok, nonzero = failed)
//
// Build option:
//   DMI_HARDRESET_EN  when defined, a DTMCS update with dmihardreset (bit 17)
//                     set aborts any transaction and clears the error state
//                     while keeping the latched address and data.
// -----------------------------------------------------------------------------
module dmi_dr_ctrl #(
    parameter int unsigned AddrWidth  = 7,
    parameter logic [2:0]  IdleCycles = 3'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dmi_clear_i,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    input  logic                 dmi_select_i,
    output logic                 dtmcs_tdo_o,
    output logic                 dmi_tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpBusy  = 2'd3;

    localparam logic [1:0] ErrNone   = 2'd0;
    localparam logic [1:0] ErrFailed = 2'd2;
    localparam logic [1:0] ErrBusy   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StWaitRead,
        StWaitWrite
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            error_q, error_d;
    logic [AddrWidth-1:0]  addr_q,  addr_d;
    logic [31:0]           data_q,  data_d;
    logic [31:0]           dtmcs_sr_q, dtmcs_sr_d;
    logic [DmiWidth-1:0]   dmi_sr_q,   dmi_sr_d;

    // Fields of the DMI DR as left by the last shift: {addr, data, op}.
    logic [AddrWidth-1:0]  dr_addr;
    logic [31:0]           dr_data;
    logic [1:0]            dr_op;
    assign {dr_addr, dr_data, dr_op} = dmi_sr_q;

    // dmihardreset and dmireset are write-only pulses and always read back 0.
    logic [31:0] dtmcs_value;
    assign dtmcs_value = {14'd0, 1'b0, 1'b0, 1'b0, IdleCycles, error_q,
                          6'(AddrWidth), 4'd1};

    logic busy;
    assign busy = (state_q != StIdle);

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        error_d          = error_q;
        addr_d           = addr_q;
        data_d           = data_q;
        dtmcs_sr_d       = dtmcs_sr_q;
        dmi_sr_d         = dmi_sr_q;
        dmi_req_valid_o  = 1'b0;
        dmi_req_op_o     = OpNop;
        dmi_resp_ready_o = 1'b0;

        // Bus-side handshakes.
        unique case (state_q)
            StIdle: begin
                // Responses to aborted requests are drained and dropped here.
                dmi_resp_ready_o = 1'b1;
            end
            StRead: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = OpRead;
                if (dmi_req_ready_i) state_d = StWaitRead;
            end
            StWrite: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = OpWrite;
                if (dmi_req_ready_i) state_d = StWaitWrite;
            end
            StWaitRead, StWaitWrite: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    if (state_q == StWaitRead) data_d = dmi_resp_data_i;
                    if (dmi_resp_resp_i != 2'd0) error_d = ErrFailed;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // TAP-side strobes, update > capture > shift. The TAP side is written
        // after the bus side so a busy flag raised by a capture that coincides
        // with a response wins over that response's status.
        if (update_i) begin
            if (dtmcs_select_i) begin
                if (dtmcs_sr_q[16]) error_d = ErrNone;
`ifdef DMI_HARDRESET_EN
                if (dtmcs_sr_q[17]) begin
                    state_d = StIdle;
                    error_d = ErrNone;
                end
`endif
            end else if (dmi_select_i) begin
                // A nonzero error is sticky: nothing is issued until dmireset.
                if (error_q != ErrNone) begin
                    error_d = error_q;
                end else if (busy) begin
                    error_d = ErrBusy;
                end else if (dr_op == OpRead) begin
                    addr_d  = dr_addr;
                    state_d = StRead;
                end else if (dr_op == OpWrite) begin
                    addr_d  = dr_addr;
                    data_d  = dr_data;
                    state_d = StWrite;
                end
            end
        end else if (capture_i) begin
            if (dtmcs_select_i) begin
                dtmcs_sr_d = dtmcs_value;
            end else if (dmi_select_i) begin
                if (busy) begin
                    // Scanning out while a transaction is outstanding means the
                    // debugger is going too fast; report and remember it.
                    error_d  = ErrBusy;
                    dmi_sr_d = {addr_q, data_q, OpBusy};
                end else begin
                    dmi_sr_d = {addr_q, data_q, error_q};
                end
            end
        end else if (shift_i) begin
            if (dtmcs_select_i) begin
                dtmcs_sr_d = {tdi_i, dtmcs_sr_q[31:1]};
            end else if (dmi_select_i) begin
                dmi_sr_d = {tdi_i, dmi_sr_q[DmiWidth-1:1]};
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        // rst_i and dmi_clear_i land on identical values, so one branch covers
        // both and rst_i's priority is implicit.
        if (rst_i || dmi_clear_i) begin
            state_q    <= StIdle;
            error_q    <= ErrNone;
            addr_q     <= '0;
            data_q     <= '0;
            dtmcs_sr_q <= '0;
            dmi_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            dtmcs_sr_q <= dtmcs_sr_d;
            dmi_sr_q   <= dmi_sr_d;
        end
    end

    // TDO comes straight from bit 0 of each register, so it only changes on a
    // clock edge and never follows tdi_i combinationally.
    assign dtmcs_tdo_o    = dtmcs_sr_q[0];
    assign dmi_tdo_o      = dmi_sr_q[0];

    // addr_q/data_q cannot change in Read/Write, which keeps the request stable.
    assign dmi_req_addr_o = addr_q;
    assign dmi_req_data_o = data_q;

endmodule

// File: tb/tb_dmi_dr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmi_dr_ctrl
//
// Self-checking bench for dmi_dr_ctrl. The debugger side is driven through
// whole DR scans, the debug-module side is a scripted responder, and expected
// values come from a small transaction-level model (error/addr/data).
// -----------------------------------------------------------------------------
module tb_dmi_dr_ctrl;

    localparam int AW = 7;
    localparam int DW = AW + 34;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          dmi_clear_i;
    logic          capture_i;
    logic          shift_i;
    logic          update_i;
    logic          tdi_i;
    logic          dtmcs_select_i;
    logic          dmi_select_i;
    logic          dtmcs_tdo_o;
    logic          dmi_tdo_o;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    logic [AW-1:0] dmi_req_addr_o;
    logic [1:0]    dmi_req_op_o;
    logic [31:0]   dmi_req_data_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    logic [31:0]   dmi_resp_data_i;
    logic [1:0]    dmi_resp_resp_i;

    dmi_dr_ctrl #(
        .AddrWidth (AW),
        .IdleCycles(3'd1)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dmi_clear_i     (dmi_clear_i),
        .capture_i       (capture_i),
        .shift_i         (shift_i),
        .update_i        (update_i),
        .tdi_i           (tdi_i),
        .dtmcs_select_i  (dtmcs_select_i),
        .dmi_select_i    (dmi_select_i),
        .dtmcs_tdo_o     (dtmcs_tdo_o),
        .dmi_tdo_o       (dmi_tdo_o),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready_i),
        .dmi_req_addr_o  (dmi_req_addr_o),
        .dmi_req_op_o    (dmi_req_op_o),
        .dmi_req_data_o  (dmi_req_data_o),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_data_i (dmi_resp_data_i),
        .dmi_resp_resp_i (dmi_resp_resp_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model of the DTM.
    logic [1:0]    m_err;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;

    function automatic logic [31:0] exp_dtmcs(input logic [1:0] err);
        return {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, err, 6'(AW), 4'd1};
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One DR scan: optional capture, len shifts (TDO sampled before each shift
    // edge), optional update. Returns the bits seen on TDO.
    task automatic dr_scan(input bit sel_dtmcs, input bit do_cap,
                           input logic [DW-1:0] din, input int len,
                           input bit do_upd, output logic [DW-1:0] dout);
        dout           = '0;
        dtmcs_select_i = sel_dtmcs;
        dmi_select_i   = !sel_dtmcs;
        if (do_cap) begin
            capture_i = 1'b1;
            step();
            capture_i = 1'b0;
        end
        shift_i = 1'b1;
        for (int i = 0; i < len; i++) begin
            tdi_i   = din[i];
            dout[i] = sel_dtmcs ? dtmcs_tdo_o : dmi_tdo_o;
            step();
        end
        shift_i = 1'b0;
        tdi_i   = 1'b0;
        if (do_upd) begin
            update_i = 1'b1;
            step();
            update_i = 1'b0;
        end
        dtmcs_select_i = 1'b0;
        dmi_select_i   = 1'b0;
    endtask

    // Debug-module responder for one request that was issued by the previous
    // update edge; checks the request and updates the model.
    task automatic dm_serve(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, input int rdy_dly,
                            input int rsp_dly, input logic [1:0] status,
                            input logic [31:0] rdata, input string tag);
        for (int c = 0; c <= rdy_dly; c++) begin
            n_tests++;
            if (dmi_req_valid_o !== 1'b1 || dmi_req_op_o !== op || dmi_req_addr_o !== addr ||
                (op == 2'd2 && dmi_req_data_o !== wdata)) begin
                n_fail++;
                $display("FAIL %s req cyc%0d: got v=%b op=%0d a=%h d=%h want v=1 op=%0d a=%h d=%h",
                         tag, c, dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o,
                         op, addr, wdata);
            end
            if (c == rdy_dly) dmi_req_ready_i = 1'b1;
            step();
        end
        dmi_req_ready_i = 1'b0;
        for (int c = 0; c <= rsp_dly; c++) begin
            n_tests++;
            if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL %s wait cyc%0d: got v=%b rr=%b want v=0 rr=1",
                         tag, c, dmi_req_valid_o, dmi_resp_ready_o);
            end
            if (c == rsp_dly) begin
                dmi_resp_valid_i = 1'b1;
                dmi_resp_data_i  = rdata;
                dmi_resp_resp_i  = status;
            end
            step();
        end
        dmi_resp_valid_i = 1'b0;
        dmi_resp_resp_i  = 2'd0;
        dmi_resp_data_i  = $urandom;
        if (op == 2'd1) m_data = rdata;
        if (status != 2'd0) m_err = 2'd2;
    endtask

    // DMI scan issuing {addr, data, op}, checking the captured value first.
    task automatic dmi_issue(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [1:0] op, input string tag);
        logic [DW-1:0] dout;
        dr_scan(1'b0, 1'b1, {addr, data, op}, DW, 1'b1, dout);
        n_tests++;
        if (dout !== {m_addr, m_data, m_err}) begin
            n_fail++;
            $display("FAIL %s capture: got %h want %h", tag, dout, {m_addr, m_data, m_err});
        end
    endtask

    // DTMCS scan with optional dmireset/dmihardreset, checking the capture.
    task automatic dtmcs_access(input bit dmireset, input bit hardreset, input string tag);
        logic [DW-1:0] dout;
        logic [DW-1:0] din;
        din     = '0;
        din[16] = dmireset;
        din[17] = hardreset;
        dr_scan(1'b1, 1'b1, din, 32, 1'b1, dout);
        n_tests++;
        if (dout[31:0] !== exp_dtmcs(m_err)) begin
            n_fail++;
            $display("FAIL %s dtmcs: got %h want %h", tag, dout[31:0], exp_dtmcs(m_err));
        end
        if (dmireset || hardreset) m_err = 2'd0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        n_tests++;
        if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1 ||
            dtmcs_tdo_o !== 1'b0 || dmi_tdo_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got v=%b rr=%b tdo=%b/%b want 0 1 0/0",
                     dmi_req_valid_o, dmi_resp_ready_o, dtmcs_tdo_o, dmi_tdo_o);
        end
        rst_i = 1'b0;
        step();
        n_tests++;
        if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1 || dmi_req_op_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b rr=%b op=%0d want 0 1 0",
                     dmi_req_valid_o, dmi_resp_ready_o, dmi_req_op_o);
        end
        m_err  = 2'd0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic test_dtmcs_read();
        logic [DW-1:0] dout;
        dr_scan(1'b1, 1'b1, '0, 32, 1'b1, dout);
        n_tests++;
        if (dout[31:0] !== 32'h0000_1071) begin
            n_fail++;
            $display("FAIL dtmcs_read: got %h want 00001071", dout[31:0]);
        end
    endtask

    task automatic test_dmi_write();
        dmi_issue(7'h10, 32'hDEAD_BEEF, 2'd2, "write");
        m_addr = 7'h10;
        m_data = 32'hDEAD_BEEF;
        dm_serve(2'd2, 7'h10, 32'hDEAD_BEEF, 2, 1, 2'd0, 32'h0, "write");
        dtmcs_access(1'b0, 1'b0, "write_err");
    endtask

    task automatic test_dmi_read();
        logic [DW-1:0] dout;
        dmi_issue(7'h25, 32'h0BAD_F00D, 2'd1, "read");
        m_addr = 7'h25;
        dm_serve(2'd1, 7'h25, 32'h0, 0, 2, 2'd0, 32'h1234_5678, "read");
        dr_scan(1'b0, 1'b1, '0, DW, 1'b1, dout);
        n_tests++;
        if (dout !== {7'h25, 32'h1234_5678, 2'd0}) begin
            n_fail++;
            $display("FAIL read_back: got %h want %h", dout, {7'h25, 32'h1234_5678, 2'd0});
        end
    endtask

    task automatic test_busy();
        logic [DW-1:0] dout;
        logic [AW-1:0] a;
        a = 7'h33;
        dmi_issue(a, 32'h0, 2'd1, "busy_issue");
        m_addr = a;
        dmi_req_ready_i = 1'b1;
        step();
        dmi_req_ready_i = 1'b0;
        // In WaitRead with no response: a DMI capture reports busy.
        dr_scan(1'b0, 1'b1, '0, DW, 1'b0, dout);
        n_tests++;
        if (dout !== {m_addr, m_data, 2'd3}) begin
            n_fail++;
            $display("FAIL busy_capture: got %h want %h", dout, {m_addr, m_data, 2'd3});
        end
        m_err = 2'd3;
        dtmcs_access(1'b0, 1'b0, "busy_stat");
        // Finish the outstanding read; busy stays sticky.
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'hCAFE_0001;
        step();
        dmi_resp_valid_i = 1'b0;
        m_data = 32'hCAFE_0001;
        dmi_issue(7'h44, 32'h0, 2'd1, "busy_ignored");
        n_tests++;
        if (dmi_req_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignored_req: got v=%b want 0", dmi_req_valid_o);
        end
        dtmcs_access(1'b1, 1'b0, "busy_clear");
        dmi_issue(7'h44, 32'h0, 2'd1, "busy_next_read");
        m_addr = 7'h44;
        dm_serve(2'd1, 7'h44, 32'h0, 1, 0, 2'd0, 32'h5A5A_A5A5, "busy_next_read");
        dtmcs_access(1'b0, 1'b0, "busy_final");
    endtask

    task automatic test_collide();
        logic [DW-1:0] dout;
        logic [31:0]   old;
        old = m_data;
        dmi_issue(7'h0F, 32'h0, 2'd1, "collide_issue");
        m_addr = 7'h0F;
        dmi_req_ready_i = 1'b1;
        step();
        dmi_req_ready_i = 1'b0;
        // Capture and response on the same edge in WaitRead.
        dmi_select_i     = 1'b1;
        capture_i        = 1'b1;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'h7777_1234;
        step();
        capture_i        = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dr_scan(1'b0, 1'b0, '0, DW, 1'b0, dout);
        n_tests++;
        if (dout !== {7'h0F, old, 2'd3}) begin
            n_fail++;
            $display("FAIL collide_capture: got %h want %h", dout, {7'h0F, old, 2'd3});
        end
        m_data = 32'h7777_1234;
        m_err  = 2'd3;
        dtmcs_access(1'b1, 1'b0, "collide_stat");
        dmi_issue(7'h00, 32'h0, 2'd0, "collide_applied");
    endtask

    task automatic test_failed_resp();
        dmi_issue(7'h51, 32'h1357_9BDF, 2'd2, "fail");
        m_addr = 7'h51;
        m_data = 32'h1357_9BDF;
        dm_serve(2'd2, 7'h51, 32'h1357_9BDF, 0, 0, 2'd2, 32'h0, "fail");
        dtmcs_access(1'b0, 1'b0, "fail_stat");
        dmi_issue(7'h22, 32'hFFFF_0000, 2'd2, "fail_ignored");
        n_tests++;
        if (dmi_req_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_ignored_req: got v=%b want 0", dmi_req_valid_o);
        end
        dtmcs_access(1'b1, 1'b0, "fail_clear");
        dmi_issue(7'h00, 32'h0, 2'd0, "fail_after_clear");
    endtask

    task automatic test_abort();
        dmi_issue(7'h6A, 32'hA5A5_0F0F, 2'd2, "abort");
        m_addr = 7'h6A;
        m_data = 32'hA5A5_0F0F;
        step();
        dmi_clear_i = 1'b1;
        step();
        dmi_clear_i = 1'b0;
        n_tests++;
        if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_clear: got v=%b rr=%b want 0 1", dmi_req_valid_o, dmi_resp_ready_o);
        end
        m_addr = '0;
        m_data = '0;
        m_err  = 2'd0;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'hBBBB_CCCC;
        step();
        dmi_resp_valid_i = 1'b0;
        dmi_issue(7'h00, 32'h0, 2'd0, "abort_late_resp");
`ifdef DMI_HARDRESET_EN
        dmi_issue(7'h1B, 32'h2468_ACE0, 2'd2, "hard");
        m_addr = 7'h1B;
        m_data = 32'h2468_ACE0;
        dtmcs_access(1'b0, 1'b1, "hard_reset");
        n_tests++;
        if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hard_abort: got v=%b rr=%b want 0 1", dmi_req_valid_o, dmi_resp_ready_o);
        end
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'hDDDD_EEEE;
        step();
        dmi_resp_valid_i = 1'b0;
        dmi_issue(7'h00, 32'h0, 2'd0, "hard_late_resp");
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [1:0]    op;
            logic [AW-1:0] a;
            logic [31:0]   d;
            logic [31:0]   rd;
            logic [1:0]    st;
            op = 2'($urandom_range(1, 2));
            a  = AW'($urandom);
            d  = $urandom;
            rd = $urandom;
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            dmi_issue(a, d, op, "rand");
            m_addr = a;
            if (op == 2'd2) m_data = d;
            dm_serve(op, a, d, $urandom_range(0, 3), $urandom_range(0, 3), st, rd, "rand");
            if (m_err != 2'd0) dtmcs_access(1'b1, 1'b0, "rand_clear");
        end
        dmi_issue(7'h00, 32'h0, 2'd0, "rand_final");
    endtask

    initial begin
        rst_i            = 1'b1;
        dmi_clear_i      = 1'b0;
        capture_i        = 1'b0;
        shift_i          = 1'b0;
        update_i         = 1'b0;
        tdi_i            = 1'b0;
        dtmcs_select_i   = 1'b0;
        dmi_select_i     = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i  = 32'h0;
        dmi_resp_resp_i  = 2'd0;
        test_reset();
        test_dtmcs_read();
        test_dmi_write();
        test_dmi_read();
        test_busy();
        test_collide();
        test_failed_resp();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
